ctrl_pipe_tracker: RTL and testbench

- Consumes the 20-bit control bundle produced by the opcode decoder at the ID stage and carries it through the EX, MEM and WB pipeline registers.
- Unpacks each field at the stage where it is used.
- Detects load-use hazards and inserts bubbles, which are the all-zero nop bundle.
- Applies branch flush and an external freeze, and keeps a sticky illegal-bundle flag and a saturating bubble counter for debug.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/ctrl_pipe_tracker_hazard_detect.sv | 48 ++++
 rtl/ctrl_pipe_tracker.sv | 170 +++++++++++++++++
 tb/tb_ctrl_pipe_tracker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared definitions for the 20-bit control bundle that the opcode
//            decoder emits and the pipeline tracker carries to write-back.
//            Holds bit positions, the packed bundle struct, the nop bundle,
//            opcode constants and a nop-test helper.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int CTRL_W         = 20;

    // Bit positions inside the flat bundle
    localparam int BIT_RSVD       = 19;
    localparam int BIT_LOAD       = 18;
    localparam int BIT_WRE        = 17;
    localparam int BIT_VWRE       = 16;
    localparam int BIT_WMEM_A     = 15;
    localparam int BIT_WMEM_B     = 14;
    localparam int BIT_WB_SEL_LO  = 12;
    localparam int BIT_VWB_SEL_LO = 10;
    localparam int BIT_ALU_LO     = 5;
    localparam int BIT_VALU_LO    = 0;

    // Field order matches the bit positions above, MSB first
    typedef struct packed {
        logic       rsvd;
        logic       load;
        logic       wre;
        logic       vector_wre;
        logic       wmem_a;
        logic       wmem_b;
        logic [1:0] wb_sel;
        logic [1:0] vwb_sel;
        logic [4:0] alu_op;
        logic [4:0] valu_op;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t NOP_BUNDLE = '0;

    // Opcode and select encodings shared with the decoder
    localparam logic [4:0] ALU_NOP     = 5'h00;
    localparam logic [4:0] ALU_ADD     = 5'h09;
    localparam logic [4:0] VALU_NOP    = 5'h00;
    localparam logic [4:0] VALU_ARK    = 5'h03;
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_IMM  = 2'b01;
    localparam logic [1:0] WB_SEL_MEM  = 2'b10;

    function automatic logic is_nop(input ctrl_bundle_t b);
        return (b == NOP_BUNDLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_tracker_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use compare between the EX-stage bundle and
//            the instruction currently sitting in ID.
// Ports    : ex_ctrl_i/ex_rd_i/ex_vd_i     - bundle and destinations in EX
//            id_ctrl_i                     - bundle in ID
//            id_rs*_i/id_vs*_i             - ID source indices
//            id_use_s_i/id_use_v_i         - per-source valid bits
//            hazard_o                      - load-use hazard present
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
    import ctrl_pkg::*;
#(
    parameter int RW = 4,
    parameter int VW = 3
) (
    input  ctrl_bundle_t    ex_ctrl_i,
    input  logic [RW-1:0]   ex_rd_i,
    input  logic [VW-1:0]   ex_vd_i,
    input  ctrl_bundle_t    id_ctrl_i,
    input  logic [RW-1:0]   id_rs1_i,
    input  logic [RW-1:0]   id_rs2_i,
    input  logic [VW-1:0]   id_vs1_i,
    input  logic [VW-1:0]   id_vs2_i,
    input  logic [1:0]      id_use_s_i,
    input  logic [1:0]      id_use_v_i,
    output logic            hazard_o
);

    logic w_s_match;
    logic w_v_match;

    always_comb begin
        w_s_match = ex_ctrl_i.wre &&
                    ((id_use_s_i[0] && (id_rs1_i == ex_rd_i)) ||
                     (id_use_s_i[1] && (id_rs2_i == ex_rd_i)));
        w_v_match = ex_ctrl_i.vector_wre &&
                    ((id_use_v_i[0] && (id_vs1_i == ex_vd_i)) ||
                     (id_use_v_i[1] && (id_vs2_i == ex_vd_i)));
        // A nop in ID never needs the loaded value, even if its source
        // fields happen to alias the load destination.
        hazard_o  = ex_ctrl_i.load && !is_nop(id_ctrl_i) && (w_s_match || w_v_match);
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_tracker
// Purpose  : Carries the decoder control bundle through EX, MEM and WB,
//            inserting nop bubbles on load-use hazards and branch flushes,
//            holding everything on freeze, and keeping a sticky illegal flag
//            and a saturating bubble counter.
// Ports    : clk, rst (sync, active-low)
//            id_*_i          - ID-stage bundle, destinations, sources, uses
//            flush_i         - kill the instruction leaving ID
//            freeze_i        - hold all stages
//            hazard_stall_o  - hold PC and IF/ID this cycle
//            ex_*/mem_*/wb_* - per-stage fields, all registered
//            illegal_o       - reserved bit seen since reset
//            bubble_cnt_o    - saturating count of hazard bubbles
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_tracker
    import ctrl_pkg::*;
#(
    parameter int RW    = 4,
    parameter int VW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [19:0]      id_ctrl_i,
    input  logic [RW-1:0]    id_rd_i,
    input  logic [VW-1:0]    id_vd_i,
    input  logic [RW-1:0]    id_rs1_i,
    input  logic [RW-1:0]    id_rs2_i,
    input  logic [VW-1:0]    id_vs1_i,
    input  logic [VW-1:0]    id_vs2_i,
    input  logic [1:0]       id_use_s_i,
    input  logic [1:0]       id_use_v_i,
    input  logic             flush_i,
    input  logic             freeze_i,
    output logic             hazard_stall_o,
    output logic [4:0]       ex_alu_op_o,
    output logic [4:0]       ex_valu_op_o,
    output logic             mem_we_a_o,
    output logic             mem_we_b_o,
    output logic             mem_load_o,
    output logic             wb_wre_o,
    output logic             wb_vwre_o,
    output logic [1:0]       wb_sel_o,
    output logic [1:0]       wb_vsel_o,
    output logic [RW-1:0]    wb_rd_o,
    output logic [VW-1:0]    wb_vd_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    ctrl_bundle_t     w_id_ctrl;
    ctrl_bundle_t     ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
    logic [RW-1:0]    ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic [VW-1:0]    ex_vd_q, ex_vd_d, mem_vd_q, mem_vd_d, wb_vd_q, wb_vd_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_hazard;

    assign w_id_ctrl = ctrl_bundle_t'(id_ctrl_i);

    hazard_detect #(
        .RW (RW),
        .VW (VW)
    ) u_hazard_detect (
        .ex_ctrl_i  (ex_ctrl_q),
        .ex_rd_i    (ex_rd_q),
        .ex_vd_i    (ex_vd_q),
        .id_ctrl_i  (w_id_ctrl),
        .id_rs1_i   (id_rs1_i),
        .id_rs2_i   (id_rs2_i),
        .id_vs1_i   (id_vs1_i),
        .id_vs2_i   (id_vs2_i),
        .id_use_s_i (id_use_s_i),
        .id_use_v_i (id_use_v_i),
        .hazard_o   (w_hazard)
    );

    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        ex_vd_d    = ex_vd_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_rd_d   = mem_rd_q;
        mem_vd_d   = mem_vd_q;
        wb_ctrl_d  = wb_ctrl_q;
        wb_rd_d    = wb_rd_q;
        wb_vd_d    = wb_vd_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;

        if (!freeze_i) begin
            mem_ctrl_d = ex_ctrl_q;
            mem_rd_d   = ex_rd_q;
            mem_vd_d   = ex_vd_q;
            wb_ctrl_d  = mem_ctrl_q;
            wb_rd_d    = mem_rd_q;
            wb_vd_d    = mem_vd_q;

            // Flush and hazard both drop a bubble into EX; only a hazard
            // that is not masked by a flush counts as a stall bubble.
            if (flush_i || w_hazard) begin
                ex_ctrl_d = NOP_BUNDLE;
                ex_rd_d   = '0;
                ex_vd_d   = '0;
            end else begin
                ex_ctrl_d = w_id_ctrl;
                ex_rd_d   = id_rd_i;
                ex_vd_d   = id_vd_i;
            end

            if (!flush_i && w_hazard && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (w_id_ctrl.rsvd) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_ctrl_q  <= NOP_BUNDLE;
            ex_rd_q    <= '0;
            ex_vd_q    <= '0;
            mem_ctrl_q <= NOP_BUNDLE;
            mem_rd_q   <= '0;
            mem_vd_q   <= '0;
            wb_ctrl_q  <= NOP_BUNDLE;
            wb_rd_q    <= '0;
            wb_vd_q    <= '0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            ex_vd_q    <= ex_vd_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_rd_q   <= mem_rd_d;
            mem_vd_q   <= mem_vd_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_rd_q    <= wb_rd_d;
            wb_vd_q    <= wb_vd_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stall only when the bubble actually enters EX this edge
    assign hazard_stall_o = w_hazard && !freeze_i && !flush_i;

    assign ex_alu_op_o  = ex_ctrl_q.alu_op;
    assign ex_valu_op_o = ex_ctrl_q.valu_op;
    assign mem_we_a_o   = mem_ctrl_q.wmem_a;
    assign mem_we_b_o   = mem_ctrl_q.wmem_b;
    assign mem_load_o   = mem_ctrl_q.load;
    assign wb_wre_o     = wb_ctrl_q.wre;
    assign wb_vwre_o    = wb_ctrl_q.vector_wre;
    assign wb_sel_o     = wb_ctrl_q.wb_sel;
    assign wb_vsel_o    = wb_ctrl_q.vwb_sel;
    assign wb_rd_o      = wb_rd_q;
    assign wb_vd_o      = wb_vd_q;
    assign illegal_o    = illegal_q;
    assign bubble_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe_tracker
// Purpose  : Self-checking bench for ctrl_pipe_tracker. A history queue of
//            the bundles that entered EX stands in for the pipeline; outputs
//            are read from the newest three entries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_tracker;

    localparam int TB_CNT_W = 8;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    localparam logic [19:0] ADD  = 20'h20125;
    localparam logic [19:0] LDR  = 20'h62000;
    localparam logic [19:0] VLDR = 20'h50400;
    localparam logic [19:0] ARK  = 20'h10003;
    localparam logic [19:0] STR  = 20'h08000;
    localparam logic [19:0] ILL  = 20'h80000;

    typedef struct packed {
        logic [19:0] c;
        logic [3:0]  rd;
        logic [2:0]  vd;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [19:0] id_ctrl;
    logic [3:0]  id_rd, id_rs1, id_rs2;
    logic [2:0]  id_vd, id_vs1, id_vs2;
    logic [1:0]  id_use_s, id_use_v;
    logic        flush, freeze;
    logic        hazard_stall, mem_we_a, mem_we_b, mem_load, wb_wre, wb_vwre, illegal;
    logic [4:0]  ex_alu_op, ex_valu_op;
    logic [1:0]  wb_sel, wb_vsel;
    logic [3:0]  wb_rd;
    logic [2:0]  wb_vd;
    logic [TB_CNT_W-1:0] bubble_cnt;

    int   tests = 0;
    int   fails = 0;
    ent_t hist[$];
    bit   m_ill;
    int   m_cnt;

    always #5 clk = ~clk;

    ctrl_pipe_tracker #(.RW(4), .VW(3), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_ctrl_i(id_ctrl), .id_rd_i(id_rd), .id_vd_i(id_vd),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_vs1_i(id_vs1), .id_vs2_i(id_vs2),
        .id_use_s_i(id_use_s), .id_use_v_i(id_use_v),
        .flush_i(flush), .freeze_i(freeze),
        .hazard_stall_o(hazard_stall),
        .ex_alu_op_o(ex_alu_op), .ex_valu_op_o(ex_valu_op),
        .mem_we_a_o(mem_we_a), .mem_we_b_o(mem_we_b), .mem_load_o(mem_load),
        .wb_wre_o(wb_wre), .wb_vwre_o(wb_vwre), .wb_sel_o(wb_sel), .wb_vsel_o(wb_vsel),
        .wb_rd_o(wb_rd), .wb_vd_o(wb_vd),
        .illegal_o(illegal), .bubble_cnt_o(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back('0);
        m_ill = 1'b0;
        m_cnt = 0;
    endtask

    // Load-use rule taken straight from the bundle bit layout
    function automatic bit m_hazard();
        ent_t e = hist[2];
        bit s, v;
        s = e.c[17] && ((id_use_s[0] && id_rs1 == e.rd) || (id_use_s[1] && id_rs2 == e.rd));
        v = e.c[16] && ((id_use_v[0] && id_vs1 == e.vd) || (id_use_v[1] && id_vs2 == e.vd));
        return e.c[18] && (id_ctrl != 20'h0) && (s || v);
    endfunction

    task automatic check_all(input bit hz);
        ent_t e = hist[2];
        ent_t m = hist[1];
        ent_t w = hist[0];
        chk("hazard_stall", hazard_stall, hz && !freeze && !flush);
        chk("ex_alu_op",    ex_alu_op,    e.c[9:5]);
        chk("ex_valu_op",   ex_valu_op,   e.c[4:0]);
        chk("mem_we_a",     mem_we_a,     m.c[15]);
        chk("mem_we_b",     mem_we_b,     m.c[14]);
        chk("mem_load",     mem_load,     m.c[18]);
        chk("wb_wre",       wb_wre,       w.c[17]);
        chk("wb_vwre",      wb_vwre,      w.c[16]);
        chk("wb_sel",       wb_sel,       w.c[13:12]);
        chk("wb_vsel",      wb_vsel,      w.c[11:10]);
        chk("wb_rd",        wb_rd,        w.rd);
        chk("wb_vd",        wb_vd,        w.vd);
        chk("illegal",      illegal,      m_ill);
        chk("bubble_cnt",   bubble_cnt,   m_cnt);
    endtask

    task automatic update(input bit hz);
        ent_t n;
        if (!rst) begin
            model_reset();
        end else if (!freeze) begin
            if (id_ctrl[19]) m_ill = 1'b1;
            n = '0;
            if (flush) begin
                n = '0;
            end else if (hz) begin
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                n.c  = id_ctrl;
                n.rd = id_rd;
                n.vd = id_vd;
            end
            hist.push_back(n);
            void'(hist.pop_front());
        end
    endtask

    // Called just after a negedge with inputs already driven
    task automatic cycle();
        bit hz;
        #1;
        hz = m_hazard();
        check_all(hz);
        @(posedge clk);
        update(hz);
        @(negedge clk);
    endtask

    task automatic set_id(input logic [19:0] c, input logic [3:0] rd, input logic [2:0] vd,
                          input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [2:0] vs1, input logic [2:0] vs2,
                          input logic [1:0] us, input logic [1:0] uv);
        id_ctrl = c; id_rd = rd; id_vd = vd; id_rs1 = rs1; id_rs2 = rs2;
        id_vs1 = vs1; id_vs2 = vs2; id_use_s = us; id_use_v = uv;
    endtask

    task automatic nop();
        set_id(20'h0, 4'd0, 3'd0, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        cycle();                       // outputs all zero after reset
        rst = 1'b1;

        // Plain add streams to WB in three cycles
        set_id(ADD, 4'd3, 3'd0, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        nop();
        cycle(); cycle();
        chk("t1_wb_wre", wb_wre, 1);
        chk("t1_wb_rd", wb_rd, 3);
        chk("t1_stall", hazard_stall, 0);

        // Scalar load-use: one-cycle stall, one bubble
        set_id(LDR, 4'd5, 3'd0, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        set_id(ADD, 4'd6, 3'd0, 4'd5, 4'd0, 3'd0, 3'd0, 2'b01, 2'b00);
        #1 chk("t2_stall", hazard_stall, 1);
        cycle(); cycle();
        nop();
        cycle(); cycle();
        chk("t2_cnt", bubble_cnt, 1);

        // Vector load-use on source 2
        set_id(VLDR, 4'd0, 3'd2, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        set_id(ARK, 4'd0, 3'd4, 4'd0, 4'd0, 3'd5, 3'd2, 2'b00, 2'b10);
        #1 chk("t3_vstall", hazard_stall, 1);
        cycle(); cycle();
        // Scalar rd=2 against rs1=2
        set_id(LDR, 4'd2, 3'd0, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        set_id(ADD, 4'd1, 3'd0, 4'd2, 4'd0, 3'd0, 3'd0, 2'b01, 2'b00);
        #1 chk("t3_sstall", hazard_stall, 1);
        cycle(); cycle();
        // Vector load vd=2 does not block a scalar rs=2
        set_id(VLDR, 4'd0, 3'd2, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        set_id(ADD, 4'd1, 3'd0, 4'd2, 4'd0, 3'd0, 3'd0, 2'b01, 2'b00);
        #1 chk("t3_cross", hazard_stall, 0);
        cycle();

        // Flush masks a hazard
        set_id(LDR, 4'd7, 3'd0, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        set_id(ADD, 4'd1, 3'd0, 4'd7, 4'd0, 3'd0, 3'd0, 2'b01, 2'b00);
        flush = 1'b1;
        #1 chk("t4_flush_stall", hazard_stall, 0);
        cycle();
        flush = 1'b0;
        chk("t4_flush_ex", ex_alu_op, 0);
        chk("t4_flush_cnt", bubble_cnt, 3);
        // Freeze holds a pending hazard for three cycles
        set_id(LDR, 4'd7, 3'd0, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        set_id(ADD, 4'd1, 3'd0, 4'd7, 4'd0, 3'd0, 3'd0, 2'b01, 2'b00);
        freeze = 1'b1;
        repeat (3) begin
            #1 chk("t4_frz_stall", hazard_stall, 0);
            cycle();
        end
        freeze = 1'b0;
        #1 chk("t4_post_frz", hazard_stall, 1);
        cycle(); cycle();

        // Sticky illegal flag, cleared only by reset
        set_id(ILL, 4'd0, 3'd0, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        nop();
        repeat (3) cycle();
        chk("t5_ill_set", illegal, 1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("t5_ill_clr", illegal, 0);

        // Randomised traffic including flush, freeze and occasional reset
        for (int i = 0; i < 3000; i++) begin
            set_id(20'($urandom) & 20'h7FFFF, 4'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   2'($urandom), 2'($urandom));
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 99) != 0);
            cycle();
        end
        flush = 1'b0; freeze = 1'b0; rst = 1'b1;

        // Counter saturates without wrapping
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        set_id(LDR, 4'd1, 3'd0, 4'd1, 4'd0, 3'd0, 3'd0, 2'b01, 2'b00);
        repeat (2 * CNT_MAX + 40) cycle();
        chk("t6_sat", bubble_cnt, CNT_MAX);

        // Reset with a store in MEM leaves no strobe behind
        nop();
        cycle();
        set_id(STR, 4'd0, 3'd0, 4'd0, 4'd0, 3'd0, 3'd0, 2'b00, 2'b00);
        cycle();
        nop();
        cycle();
        chk("t6_str_mem", mem_we_a, 1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("t6_rst_we_a", mem_we_a, 0);
        chk("t6_rst_wb", wb_wre, 0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
